ibex_ex_sequencer: RTL and testbench

- Parametrised execute-stage sequencer; successor to the fixed ALU + MUL/DIV execute block.
- Issues one operation at a time to one of NUM_UNITS functional units (single-cycle or multi-cycle) over a valid/ready handshake.
- Collects the selected unit's result into a registered output stage, with flush, unit kill and a hang timeout.
- Sits between ID-stage issue logic and writeback.

---
 rtl/ibex_ex_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ibex_ex_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ex_sequencer.sv
// Execute-stage sequencer: issues one operation at a time to NUM_UNITS functional
// units and returns the selected unit's result through a registered output stage.
module ibex_ex_sequencer #(
  parameter int unsigned          NUM_UNITS         = 4,
  parameter int unsigned          WIDTH             = 32,
  parameter int unsigned          TAG_W             = 5,
  parameter logic [NUM_UNITS-1:0] SINGLE_CYCLE_MASK = 4'b0001,
  parameter int unsigned          TIMEOUT_CYCLES    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [3:0]                 issue_unit_i,
  input  logic [TAG_W-1:0]           issue_tag_i,
  output logic [NUM_UNITS-1:0]       unit_start_o,
  output logic [NUM_UNITS-1:0]       unit_kill_o,
  input  logic [NUM_UNITS-1:0]       unit_done_i,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [WIDTH-1:0]           result_o,
  output logic [TAG_W-1:0]           result_tag_o,
  output logic                       result_err_o,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic [1:0]                 dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the result payload is held while valid && !ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           unit_q, unit_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 timeout;
  logic                 issue_legal;
  logic                 issue_single;
  logic [WIDTH-1:0]     issue_data;
  logic [NUM_UNITS-1:0] issue_onehot;
  logic                 busy_done;
  logic [WIDTH-1:0]     busy_data;
  logic [NUM_UNITS-1:0] busy_onehot;

  // Decode the offered unit and the unit in progress; out-of-range indices match nothing.
  always_comb begin
    issue_legal  = 1'b0;
    issue_single = 1'b0;
    issue_data   = '0;
    issue_onehot = '0;
    busy_done    = 1'b0;
    busy_data    = '0;
    busy_onehot  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (issue_unit_i == 4'(u)) begin
        issue_legal     = 1'b1;
        issue_single    = SINGLE_CYCLE_MASK[u];
        issue_data      = unit_result_i[u*WIDTH +: WIDTH];
        issue_onehot[u] = 1'b1;
      end
      if (unit_q == 4'(u)) begin
        busy_done      = unit_done_i[u];
        busy_data      = unit_result_i[u*WIDTH +: WIDTH];
        busy_onehot[u] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    unit_d        = unit_q;
    tag_d         = tag_q;
    res_d         = res_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    unit_start_o  = '0;
    unit_kill_o   = '0;
    issue_ready_o = !flush_i && (state_q == IDLE || (state_q == OUT && result_ready_i));
    accept        = issue_valid_i && issue_ready_o;
    timeout       = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    if (flush_i) begin
      state_d = IDLE;
      err_d   = 1'b0;
      if (state_q == BUSY) unit_kill_o = busy_onehot;
    end else begin
      case (state_q)
        BUSY: begin
          if (busy_done) begin
            state_d = OUT;
            res_d   = busy_data;
            err_d   = 1'b0;
          end else if (timeout) begin
            unit_kill_o = busy_onehot;
            state_d     = OUT;
            res_d       = '0;
            err_d       = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OUT:     if (result_ready_i) state_d = IDLE;
        default: ;
      endcase

      // A new accept overrides the drain of OUT so results can stream back-to-back.
      if (accept) begin
        unit_d = issue_unit_i;
        tag_d  = issue_tag_i;
        if (!issue_legal) begin
          state_d = OUT;
          res_d   = '0;
          err_d   = 1'b1;
        end else if (issue_single) begin
          state_d = OUT;
          res_d   = issue_data;
          err_d   = 1'b0;
        end else begin
          state_d      = BUSY;
          cnt_d        = '0;
          unit_start_o = issue_onehot;
        end
      end
    end

    // The operation is discarded by reset, so no unit is started or killed.
    if (rst_i) begin
      unit_start_o = '0;
      unit_kill_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      unit_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result_valid_o = (state_q == OUT);
  assign result_o       = res_q;
  assign result_tag_o   = tag_q;
  assign result_err_o   = err_q;
  assign busy_o         = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ibex_ex_sequencer.sv
// Bench for ibex_ex_sequencer: directed scenarios with literal expectations, then
// random traffic, all cross-checked every cycle against a transaction-level model.
module tb_ibex_ex_sequencer;

  localparam int NU = 4;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int TO = 8;
  localparam logic [NU-1:0] SC_MASK = 4'b0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_unit;
  logic [TW-1:0]     issue_tag;
  logic [NU-1:0]     unit_start;
  logic [NU-1:0]     unit_kill;
  logic [NU-1:0]     unit_done;
  logic [NU*W-1:0]   unit_result;
  logic              result_valid;
  logic              result_ready;
  logic [W-1:0]      result;
  logic [TW-1:0]     result_tag;
  logic              result_err;
  logic              flush;
  logic              busy;
  logic [1:0]        dbg_state;

  ibex_ex_sequencer #(
    .NUM_UNITS(NU), .WIDTH(W), .TAG_W(TW),
    .SINGLE_CYCLE_MASK(SC_MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_unit_i(issue_unit), .issue_tag_i(issue_tag),
    .unit_start_o(unit_start), .unit_kill_o(unit_kill),
    .unit_done_i(unit_done), .unit_result_i(unit_result),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_o(result), .result_tag_o(result_tag), .result_err_o(result_err),
    .flush_i(flush), .busy_o(busy), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds {err, tag, data} of the result the DUT must be presenting.
  logic [1+TW+W-1:0] exp_q[$];
  bit                m_pend  = 1'b0;
  logic [1:0]        m_unit  = '0;
  logic [TW-1:0]     m_tag   = '0;
  int                m_start = 0;
  int                cyc     = 0;

  always @(negedge clk) begin : model
    bit            has, rdy, acc, legal, single;
    int            age;
    logic [NU-1:0] e_start, e_kill;
    has     = (exp_q.size() != 0);
    rdy     = !flush && ((!m_pend && !has) || (has && result_ready));
    acc     = issue_valid && rdy;
    legal   = (int'(issue_unit) < NU);
    single  = legal && SC_MASK[issue_unit[1:0]];
    age     = cyc - m_start;
    e_start = '0;
    e_kill  = '0;
    if (acc && legal && !single && !rst) e_start[issue_unit[1:0]] = 1'b1;
    if (m_pend && !rst && (flush || (!unit_done[m_unit] && age == TO))) e_kill[m_unit] = 1'b1;

    if (chk_en) begin
      chk("issue_ready", 64'(issue_ready), 64'(rdy));
      chk("unit_start", 64'(unit_start), 64'(e_start));
      chk("unit_kill", 64'(unit_kill), 64'(e_kill));
      chk("result_valid", 64'(result_valid), 64'(has));
      chk("busy", 64'(busy), 64'(m_pend || has));
      if (has) chk("result_payload", 64'({result_err, result_tag, result}), 64'(exp_q[0]));
    end

    // Advance to the state after the coming rising edge.
    if (rst || flush) begin
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        if (unit_done[m_unit]) begin
          exp_q.push_back({1'b0, m_tag, unit_result[int'(m_unit)*W +: W]});
          m_pend = 1'b0;
        end else if (age == TO) begin
          exp_q.push_back({1'b1, m_tag, 32'h0});
          m_pend = 1'b0;
        end
      end else if (has && result_ready) begin
        void'(exp_q.pop_front());
      end
      if (acc) begin
        m_tag = issue_tag;
        if (!legal) exp_q.push_back({1'b1, issue_tag, 32'h0});
        else if (single) exp_q.push_back({1'b0, issue_tag, unit_result[int'(issue_unit)*W +: W]});
        else begin
          m_pend  = 1'b1;
          m_unit  = issue_unit[1:0];
          m_start = cyc;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] u, input logic [TW-1:0] t);
    issue_valid = v;
    issue_unit  = u;
    issue_tag   = t;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; result_ready = 1'b0;
    unit_done = '0; unit_result = '0;
    issue(1'b0, 4'd0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_tag", 64'(result_tag), 64'd0);
    chk("reset_err", 64'(result_err), 64'd0);
    chk("reset_start_kill", 64'({unit_start, unit_kill}), 64'd0);
    next_cycle();

    // Single-cycle unit 0, four back-to-back operations.
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 4'd0, 5'(3 + i));
      unit_result[31:0] = 32'h1234 + 32'(i);
      next_cycle();
      chk("sc_valid", 64'(result_valid), 64'd1);
      chk("sc_result", 64'(result), 64'(32'h1234 + 32'(i)));
      chk("sc_tag", 64'(result_tag), 64'(3 + i));
      chk("sc_err", 64'(result_err), 64'd0);
    end
    issue(1'b0, 4'd0, '0);
    next_cycle();
    chk("sc_drain", 64'(result_valid), 64'd0);

    // Multi-cycle unit 2, done five cycles after start; done[1] meanwhile is ignored.
    issue(1'b1, 4'd2, 5'd9);
    @(negedge clk);
    chk("mc_start", 64'(unit_start), 64'b0100);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    result_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      unit_done = (k == 2) ? 4'b0010 : (k == 5) ? 4'b0100 : 4'b0000;
      if (k == 5) unit_result[64 +: 32] = 32'hDEADBEEF;
      @(negedge clk);
      chk("mc_wait_valid", 64'(result_valid), 64'd0);
      chk("mc_wait_busy", 64'(busy), 64'd1);
      next_cycle();
    end
    unit_done = '0;
    chk("mc_valid", 64'(result_valid), 64'd1);
    chk("mc_result", 64'(result), 64'hDEADBEEF);
    chk("mc_tag", 64'(result_tag), 64'd9);

    // Backpressure for three cycles with a new single-cycle issue pending.
    issue(1'b1, 4'd0, 5'd11);
    unit_result[31:0] = 32'h55;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_ready", 64'(issue_ready), 64'd0);
      chk("bp_hold", 64'(result), 64'hDEADBEEF);
      next_cycle();
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 64'(issue_ready), 64'd1);
    next_cycle();
    chk("bp_new_result", 64'(result), 64'h55);
    chk("bp_new_tag", 64'(result_tag), 64'd11);
    issue(1'b0, 4'd0, '0);
    next_cycle();
    chk("bp_drain", 64'(result_valid), 64'd0);

    // Timeout on unit 1: kill eight cycles after start, error result.
    issue(1'b1, 4'd1, 5'd7);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      chk("to_nokill", 64'(unit_kill), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_kill", 64'(unit_kill), 64'b0010);
    next_cycle();
    chk("to_valid", 64'(result_valid), 64'd1);
    chk("to_result", 64'(result), 64'd0);
    chk("to_err", 64'(result_err), 64'd1);
    next_cycle();

    // Done on the timeout cycle wins.
    issue(1'b1, 4'd1, 5'd8);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    for (int k = 1; k < TO; k++) next_cycle();
    unit_done = 4'b0010;
    unit_result[32 +: 32] = 32'hABCD;
    @(negedge clk);
    chk("tod_nokill", 64'(unit_kill), 64'd0);
    next_cycle();
    unit_done = '0;
    chk("tod_result", 64'(result), 64'hABCD);
    chk("tod_err", 64'(result_err), 64'd0);
    next_cycle();

    // Flush during BUSY on unit 3 with a same-cycle done.
    issue(1'b1, 4'd3, 5'd12);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    next_cycle();
    flush = 1'b1;
    unit_done = 4'b1000;
    unit_result[96 +: 32] = 32'h999;
    issue(1'b1, 4'd2, 5'd1);
    @(negedge clk);
    chk("fl_kill", 64'(unit_kill), 64'b1000);
    chk("fl_ready", 64'(issue_ready), 64'd0);
    chk("fl_start", 64'(unit_start), 64'd0);
    next_cycle();
    flush = 1'b0;
    unit_done = '0;
    issue(1'b0, 4'd0, '0);
    chk("fl_valid", 64'(result_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);

    // Flush during OUT drops valid but keeps the data.
    result_ready = 1'b0;
    issue(1'b1, 4'd0, 5'd13);
    unit_result[31:0] = 32'h77;
    next_cycle();
    issue(1'b0, 4'd0, '0);
    chk("fo_valid", 64'(result_valid), 64'd1);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    chk("fo_dropped", 64'(result_valid), 64'd0);
    chk("fo_kept", 64'(result), 64'h77);

    // Illegal unit index.
    result_ready = 1'b1;
    issue(1'b1, 4'd7, 5'd14);
    @(negedge clk);
    chk("il_start", 64'(unit_start), 64'd0);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    chk("il_valid", 64'(result_valid), 64'd1);
    chk("il_result", 64'(result), 64'd0);
    chk("il_err", 64'(result_err), 64'd1);
    next_cycle();

    // Reset in the middle of a multi-cycle operation.
    issue(1'b1, 4'd2, 5'd15);
    next_cycle();
    issue(1'b0, 4'd0, '0);
    chk("rb_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_nokill", 64'(unit_kill), 64'd0);
    next_cycle();
    rst = 1'b0;
    chk("rb_valid", 64'(result_valid), 64'd0);
    chk("rb_busy_low", 64'(busy), 64'd0);
    chk("rb_payload", 64'({result_err, result_tag, result}), 64'd0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 24) == 0);
      result_ready = ($urandom_range(0, 9) < 7);
      unit_done    = 4'($urandom) & 4'($urandom);
      unit_result  = {$urandom, $urandom, $urandom, $urandom};
      issue($urandom_range(0, 9) < 6,
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
            5'($urandom));
      next_cycle();
    end

    rst = 1'b0; flush = 1'b0; unit_done = '0;
    issue(1'b0, 4'd0, '0);
    repeat (4) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
